restoring_divider64: RTL

Iterative unsigned 64-by-32 restoring divider that recovers the 32-bit operands from a 64-bit product. It resolves one quotient bit per cycle and completes in 32 cycles. It sits beside the 32-bit Wallace multiplier in the arithmetic library and consumes the same 64-bit result width. Valid/ready handshakes sit on both the input and output sides.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_step.sv | 31 +++
 rtl/restoring_divider64.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared constants, FSM state type and a counter-width helper for the
// restoring 64-by-32 divider.
// No ports (package).
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int WIDTH  = 32;          // divisor / quotient / remainder width
    localparam int DWIDTH = 2 * WIDTH;   // dividend width

    // Step counter must hold WIDTH-1 plus one spare bit so it never wraps.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
// Ports:
//   r_i       partial remainder before the step (always < divisor in range)
//   bit_i     next dividend bit shifted in at the LSB
//   divisor_i divisor
//   r_o       partial remainder after the step
//   q_bit_o   resolved quotient bit
// -----------------------------------------------------------------------------
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);

    logic fits;

    // The trial value is WIDTH+1 bits wide; the comparison needs the full
    // width, but the difference only ever needs its low WIDTH bits because a
    // successful subtraction always leaves a value below the divisor.
    assign fits    = ({r_i, bit_i} >= {1'b0, divisor_i});
    assign r_o     = {r_i[WIDTH-2:0], bit_i} - (fits ? divisor_i : '0);
    assign q_bit_o = fits;

endmodule : divider_step

// File: rtl/restoring_divider64.sv
// -----------------------------------------------------------------------------
// restoring_divider64
// Iterative unsigned 2*WIDTH-by-WIDTH restoring divider, one quotient bit per
// cycle, WIDTH cycles per operation, valid/ready on both sides.
// Optional build macro: DIVIDER_FAST_EXCEPTION_EN -- divide-by-zero and
// quotient overflow finish immediately with err=1, quotient all ones,
// remainder 0. Without it, err is tied low and every operation runs all steps.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   dividend, divisor     unsigned operands
//   out_valid / out_ready result handshake (valid held until accepted)
//   quotient, remainder   unsigned result
//   err                   divide-by-zero / overflow flag
// -----------------------------------------------------------------------------
module restoring_divider64 #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               err
);

    import divider_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] step_r;
    logic             step_bit;

    // The dividend's next bit always sits at the MSB of the quotient register,
    // which doubles as the shift register for the not-yet-consumed low half.
    divider_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (r_q),
        .bit_i     (q_q[WIDTH-1]),
        .divisor_i (div_q),
        .r_o       (step_r),
        .q_bit_o   (step_bit)
    );

`ifdef DIVIDER_FAST_EXCEPTION_EN
    logic err_q, err_d;
    logic exception;

    // Zero divisor is also caught by the compare; spelled out for clarity.
    assign exception = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
`ifdef DIVIDER_FAST_EXCEPTION_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d   = divisor;
                    r_d     = dividend[2*WIDTH-1:WIDTH];
                    q_d     = dividend[WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIVIDER_FAST_EXCEPTION_EN
                    err_d   = 1'b0;
                    if (exception) begin
                        err_d   = 1'b1;
                        q_d     = '1;
                        r_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A simultaneous in_valid is not looked at here; it will be
                // taken in IDLE on the following cycle if still asserted.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too because quotient and
            // remainder are driven straight from them and must read 0.
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
`ifdef DIVIDER_FAST_EXCEPTION_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
`ifdef DIVIDER_FAST_EXCEPTION_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = r_q;
`ifdef DIVIDER_FAST_EXCEPTION_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule : restoring_divider64
